// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter.
//   state_t        : converter FSM states (idle, converting, result pulse)
//   DEF_DIGITS     : default number of packed BCD digits
//   DEF_BIN_W      : default binary result width (2^BIN_W > 10^DIGITS - 1)
//   BCD_MAX_DIGIT  : largest legal BCD digit value
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_DONE
    } state_t;

    localparam int unsigned DEF_DIGITS    = 4;
    localparam int unsigned DEF_BIN_W     = 14;
    localparam logic [3:0]  BCD_MAX_DIGIT = 4'd9;

endpackage

// File: rtl/bcd_digit_mac.sv
// One multiply-accumulate step of BCD-to-binary conversion (combinational).
//   acc_in    : running binary accumulator
//   digit     : next BCD digit, most significant first
//   acc_out   : acc_in*10 + digit, wrapping mod 2^BIN_W
//   digit_bad : digit is not a legal BCD value (> 9)
module bcd_digit_mac
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W = DEF_BIN_W
) (
    input  logic [BIN_W-1:0] acc_in,
    input  logic [3:0]       digit,
    output logic [BIN_W-1:0] acc_out,
    output logic             digit_bad
);

    // x10 built from two shifts so no multiplier is inferred.
    always_comb begin
        acc_out   = (acc_in << 3) + (acc_in << 1) + BIN_W'(digit);
        digit_bad = (digit > BCD_MAX_DIGIT);
    end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter: one digit per clock, MSD first.
//   clk     : system clock, rising edge
//   rst     : asynchronous active-high reset
//   start   : conversion request, sampled only while idle
//   bcd_in  : packed BCD word, MSD in top nibble, captured on accepted start
//   busy    : high while digits are being processed
//   done    : one-cycle pulse when bin_out/err carry a new result
//   err     : some digit of the last word was > 9
//   bin_out : converted value, held until the next result
module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = DEF_DIGITS,
    parameter int unsigned BIN_W  = DEF_BIN_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [BIN_W-1:0]      bin_out
);

    localparam int unsigned CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t              state;
    state_t              state_next;
    logic [4*DIGITS-1:0] shreg;
    logic [BIN_W-1:0]    acc;
    logic [BIN_W-1:0]    acc_next;
    logic [CNT_W-1:0]    cnt;
    logic                err_acc;
    logic                digit_bad;
    logic                last_digit;

    bcd_digit_mac #(
        .BIN_W(BIN_W)
    ) u_mac (
        .acc_in    (acc),
        .digit     (shreg[4*DIGITS-1 -: 4]),
        .acc_out   (acc_next),
        .digit_bad (digit_bad)
    );

    assign last_digit = (cnt == CNT_W'(DIGITS - 1));

    // Status outputs decode the state register only: no input-to-output path.
    assign busy = (state == ST_CONV);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_CONV;
            ST_CONV: if (last_digit) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            acc     <= '0;
            cnt     <= '0;
            err_acc <= 1'b0;
            err     <= 1'b0;
            bin_out <= '0;
        end else if (state == ST_IDLE) begin
            if (start) begin
                shreg   <= bcd_in;
                acc     <= '0;
                cnt     <= '0;
                err_acc <= 1'b0;
            end
        end else if (state == ST_CONV) begin
            acc     <= acc_next;
            shreg   <= shreg << 4;
            err_acc <= err_acc | digit_bad;
            cnt     <= cnt + CNT_W'(1);
            // Publish straight from the MAC so the result lands on the final digit edge.
            if (last_digit) begin
                bin_out <= acc_next;
                err     <= err_acc | digit_bad;
            end
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq: a 4-digit/14-bit instance and a
// 2-digit/7-bit instance, checked against a weighted-sum reference model.
module tb_bcd_to_bin_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] bcd_in = '0;
    logic        busy, done, err;
    logic [13:0] bin_out;

    logic        start_s = 1'b0;
    logic [7:0]  bcd_s = '0;
    logic        busy_s, done_s, err_s;
    logic [6:0]  bin_s;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bcd_to_bin_seq #(.DIGITS(4), .BIN_W(14)) dut (
        .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in),
        .busy(busy), .done(done), .err(err), .bin_out(bin_out)
    );

    bcd_to_bin_seq #(.DIGITS(2), .BIN_W(7)) dut_small (
        .clk(clk), .rst(rst), .start(start_s), .bcd_in(bcd_s),
        .busy(busy_s), .done(done_s), .err(err_s), .bin_out(bin_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Value = sum of digit * 10^position, reduced mod 2^w; any digit > 9 flags error.
    function automatic void ref_conv(input logic [23:0] bcd, input int digits, input int w,
                                     output logic [31:0] val, output logic bad);
        longint sum;
        longint p;
        longint d;
        sum = 0;
        p   = 1;
        bad = 1'b0;
        for (int i = 0; i < digits; i++) begin
            d = longint'((bcd >> (4 * i)) & 24'hF);
            if (d > 9) bad = 1'b1;
            sum += d * p;
            p   *= 10;
        end
        val = 32'(sum % (longint'(1) << w));
    endfunction

    task automatic run_big(input logic [15:0] v, input string tag);
        logic [31:0] ev;
        logic        eb;
        ref_conv({8'h00, v}, 4, 14, ev, eb);
        @(negedge clk);
        start  = 1'b1;
        bcd_in = v;
        @(negedge clk);
        start  = 1'b0;
        bcd_in = 16'($urandom);
        check({tag, "_busy1"}, 32'(busy), 1);
        check({tag, "_nodone"}, 32'(done), 0);
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            check({tag, "_busy"}, 32'(busy), 1);
        end
        @(negedge clk);
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_busy_at_done"}, 32'(busy), 0);
        check({tag, "_bin"}, 32'(bin_out), ev);
        check({tag, "_err"}, 32'(err), 32'(eb));
        @(negedge clk);
        check({tag, "_done_clr"}, 32'(done), 0);
        check({tag, "_idle_busy"}, 32'(busy), 0);
        check({tag, "_bin_hold"}, 32'(bin_out), ev);
    endtask

    task automatic run_small(input logic [7:0] v, input string tag);
        logic [31:0] ev;
        logic        eb;
        ref_conv({16'h0000, v}, 2, 7, ev, eb);
        @(negedge clk);
        start_s = 1'b1;
        bcd_s   = v;
        @(negedge clk);
        start_s = 1'b0;
        bcd_s   = 8'($urandom);
        check({tag, "_busy1"}, 32'(busy_s), 1);
        @(negedge clk);
        check({tag, "_busy2"}, 32'(busy_s), 1);
        check({tag, "_nodone"}, 32'(done_s), 0);
        @(negedge clk);
        check({tag, "_done"}, 32'(done_s), 1);
        check({tag, "_bin"}, 32'(bin_s), ev);
        check({tag, "_err"}, 32'(err_s), 32'(eb));
        @(negedge clk);
        check({tag, "_done_clr"}, 32'(done_s), 0);
    endtask

    initial begin
        logic [15:0] v;
        logic [7:0]  vs;

        #1 rst = 1'b1;
        #2;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_bin", 32'(bin_out), 0);
        @(negedge clk);
        rst = 1'b0;

        run_big(16'h1234, "d1234");
        run_big(16'h9999, "d9999");
        run_big(16'h0000, "d0000");
        run_big(16'h12A4, "d12A4");
        run_big(16'h0042, "d0042");

        // Start held high: a fresh conversion every 6 cycles, mid-flight bcd_in ignored.
        @(negedge clk);
        start  = 1'b1;
        bcd_in = 16'h0007;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            check("held_done", 32'(done), 32'((k % 6) == 5));
            check("held_busy", 32'(busy), 32'(((k % 6) >= 1) && ((k % 6) <= 4)));
            if ((k % 6) == 5) check("held_bin", 32'(bin_out), 7);
            bcd_in = ((k % 6) == 0) ? 16'h0007 : 16'($urandom);
        end
        start = 1'b0;

        // Reset in the middle of a conversion.
        @(negedge clk);
        start  = 1'b1;
        bcd_in = 16'h5678;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("mid_busy", 32'(busy), 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_bin", 32'(bin_out), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_err", 32'(err), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("post_rst_nodone", 32'(done), 0);
        end
        run_big(16'h0100, "d0100");

        for (int i = 0; i < 16; i++) begin
            v = 16'($urandom);
            if (i % 2 == 0) begin
                for (int n = 0; n < 4; n++) v[4*n +: 4] = 4'(v[4*n +: 4] % 10);
            end
            run_big(v, "rand");
        end

        run_small(8'h99, "s99");
        run_small(8'h00, "s00");
        run_small(8'hFF, "sFF");
        for (int i = 0; i < 8; i++) begin
            vs = 8'($urandom);
            run_small(vs, "srand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
